// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - burst multiply-accumulate sequencer driving an external DSP slice
module mac_sequencer #(
    parameter int WIDTH_2 = 18,
    parameter int WIDTH_4 = 48,
    parameter int LEN_W   = 8,
    parameter int LAT     = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    input  logic [WIDTH_2-1:0] in_a,
    input  logic [WIDTH_2-1:0] in_b,
    output logic               in_ready,
    output logic [WIDTH_2-1:0] DSP_A,
    output logic [WIDTH_2-1:0] DSP_B,
    output logic [7:0]         DSP_OPMODE,
    input  logic [WIDTH_4-1:0] DSP_P,
    output logic [WIDTH_4-1:0] result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [CNT_W-1:0]   drain_cnt;
    logic               first;
    logic               accept;

    // Operands feed the slice's own A1/B1 input registers directly.
    assign DSP_A        = in_a;
    assign DSP_B        = in_b;
    assign in_ready     = (state == ACCUM);
    assign result_valid = (state == OUT);
    assign busy         = (state != IDLE);
    assign accept       = in_valid && (state == ACCUM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            remaining  <= '0;
            drain_cnt  <= '0;
            first      <= 1'b0;
            result     <= '0;
            DSP_OPMODE <= 8'h00;
        end else begin
            // One cycle of delay here lines OPMODE up with the product leaving MREG.
            if (accept) begin
                DSP_OPMODE <= first ? 8'h01 : 8'h09;
            end else begin
                DSP_OPMODE <= 8'h08;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= ACCUM;
                            remaining <= len;
                            first     <= 1'b1;
                        end else begin
                            state  <= OUT;
                            result <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        first     <= 1'b0;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state     <= DRAIN;
                            drain_cnt <= CNT_W'(LAT);
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_W'(1);
                    if (drain_cnt == CNT_W'(1)) begin
                        result <= DSP_P;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_2, default 18, giving the operand width of A and B.
REQ-002 SHALL have parameter WIDTH_4, default 48, giving the P and result width.
REQ-003 SHALL have parameter LEN_W, default 8, giving the width of the burst length.
REQ-004 SHALL have parameter LAT, default 3, giving the cycles from operand presentation on DSP_A/DSP_B to the matching DSP_P.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begins a burst; sampled only in IDLE.
REQ-008 SHALL have port len, input, LEN_W bits: number of operand pairs, captured with start.
REQ-009 SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-010 SHALL have port in_a, input, WIDTH_2 bits: operand A, unsigned.
REQ-011 SHALL have port in_b, input, WIDTH_2 bits: operand B, unsigned.
REQ-012 SHALL have port in_ready, output, 1 bit: the block accepts a pair.
REQ-013 SHALL have port DSP_A, output, WIDTH_2 bits, driven to the slice A port.
REQ-014 SHALL have port DSP_B, output, WIDTH_2 bits, driven to the slice B port.
REQ-015 SHALL have port DSP_OPMODE, output, 8 bits, driven to the slice OPMODE port.
REQ-016 SHALL have port DSP_P, input, WIDTH_4 bits, taken from the slice P output.
REQ-017 SHALL have port result, output, WIDTH_4 bits: the accumulated sum.
REQ-018 SHALL have port result_valid, output, 1 bit: result is held stable while asserted.
REQ-019 SHALL have port result_ready, input, 1 bit: the consumer accepts result.
REQ-020 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ACCUM, DRAIN and OUT.
REQ-022 IDLE SHALL transition as follows.
- start=1 with len>0: go to ACCUM; load remaining=len.
- start=1 with len=0: go to OUT with result=0.
- Otherwise stay in IDLE.
REQ-023 in_ready SHALL equal 1 exactly when state=ACCUM; a pair is accepted on a cycle with in_valid & in_ready.
REQ-024 DSP_A and DSP_B SHALL equal in_a and in_b combinationally, with no register.
REQ-025 DSP_OPMODE SHALL be registered and reflect the previous cycle:
- 0x01 if a pair was accepted and it was the first of the burst (X=M, Z=0).
- 0x09 if a later pair of the burst was accepted (X=M, Z=P).
- 0x08 otherwise (X=0, Z=P, so P holds).
REQ-026 This one-cycle OPMODE delay SHALL align with the slice's OPMODEREG=1, A1REG/B1REG=1, MREG=1 and PREG=1 settings.
REQ-027 An in_valid bubble in ACCUM SHALL leave the accumulation unchanged, via DSP_OPMODE=0x08 two cycles later at the post-adder.
REQ-028 Each accepted pair SHALL decrement remaining; accepting the last pair SHALL move the FSM to DRAIN with drain counter=LAT.
REQ-029 DRAIN SHALL decrement the counter each cycle; when it reaches 1 the block SHALL capture DSP_P into result and move to OUT.
REQ-030 The capture SHALL occur exactly LAT cycles after the accept cycle of the last pair.
REQ-031 OUT SHALL assert result_valid; on result_valid & result_ready the FSM SHALL return to IDLE and deassert result_valid on the next cycle.
REQ-032 result and result_valid SHALL hold unchanged while result_ready=0, with no timeout.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 Arithmetic SHALL be unsigned and modulo 2^WIDTH_4; the block SHALL perform no overflow detection.
REQ-035 A start held high through OUT→IDLE SHALL begin a new burst on the first IDLE cycle.

Reset
REQ-036 RST=1 SHALL force state=IDLE from any state, including mid-ACCUM and mid-DRAIN.
REQ-037 Reset values SHALL be:
- remaining=0, drain counter=0.
- result=0, result_valid=0, in_ready=0, busy=0.
- DSP_OPMODE=0x00.
REQ-038 After reset the block SHALL accept start on the first cycle with RST=0.

Verification
REQ-039 The bench SHALL cover these directed scenarios, each against a cycle-accurate slice model with default attributes:
- Basic burst: len=3, pairs (2,3),(4,5),(1,7) back-to-back → result=33, result_valid exactly 3 cycles after the last accept, then return to IDLE.
- Bubble: same pairs with in_valid low for 2 cycles between pairs 1 and 2 → result=33; DSP_OPMODE shows 0x08 on the bubble cycles.
- Max operands: len=2, pairs (0x3FFFF,0x3FFFF) twice → result=0x1_FFFF0_0002 (i.e. 2×0xFFFF80001 = 0x1FFFF00002).
- Zero length and backpressure: len=0 → result=0, result_valid one cycle after start; result_ready held low 5 cycles → result stable, busy=1 throughout.
- Reset mid-burst: RST pulsed after 2 of 4 pairs → IDLE, in_ready=0, result_valid=0; a subsequent len=1 burst with (6,7) → result=42.
- Ignored start: start pulsed during ACCUM and DRAIN → no change to remaining or result.
